// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter.
//
// Serialises one byte per accepted TX_EN strobe as an asynchronous frame:
// start bit (0), 8 data bits LSB first, optional parity bit, then 1 or 2
// stop bits (1). Every bit is held for BAUD_DIV clocks.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   TX_EN      send strobe, sampled only while idle
//   TX_DATA    byte to send, captured on the accepting edge
//   TX_STATUS  1 while a frame is in progress
//   TX_DONE    one-cycle pulse in the first idle cycle after a frame
//   UART_TX    serial line, idle high
module uart_tx #(
    parameter int unsigned BAUD_DIV   = 10417,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TX_EN,
    input  logic [7:0] TX_DATA,
    output logic       TX_STATUS,
    output logic       TX_DONE,
    output logic       UART_TX
);

    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_tx: illegal parameters BAUD_DIV=%0d STOP_BITS=%0d", BAUD_DIV, STOP_BITS);
    end

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_EN    = (PARITY_EN != 0);
    localparam logic        PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_tick;

    assign baud_tick = (baud_q == BAUD_LAST);

    // tx_q always holds the level of the bit currently on the line; on each
    // terminal count the next bit is loaded so it appears on the same edge
    // that starts its BAUD_DIV window. The shift register is pre-shifted, so
    // shift_q[0] is always the next data bit to present.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (TX_EN) begin
                    shift_d = TX_DATA;
                    par_d   = (^TX_DATA) ^ PAR_ODD;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PAR_EN) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            STOP: begin
                // bit_q counts completed stop bits
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign UART_TX   = tx_q;
    assign TX_STATUS = busy_q;
    assign TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- scoreboard bench for uart_tx.
//
// Three instances with different configurations share one scoreboard. The
// stimulus side decides from frame-length arithmetic alone whether a TX_EN
// edge is accepted and, if so, queues the byte with its acceptance cycle.
// The monitor captures each busy window cycle by cycle and compares it with
// a waveform built from the frame rules (start, data LSB first, parity,
// stop bits, each held BAUD_DIV clocks).
module tb_uart_tx;

    localparam int unsigned NDUT = 3;
    localparam int unsigned CDIV  [NDUT] = '{4, 4, 3};
    localparam int unsigned CPEN  [NDUT] = '{0, 1, 1};
    localparam int unsigned CPODD [NDUT] = '{0, 0, 1};
    localparam int unsigned CSTOP [NDUT] = '{1, 2, 1};

    typedef struct {
        int unsigned id;
        logic [7:0]  data;
        int unsigned acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en  [NDUT];
    logic [7:0] dat [NDUT];
    logic       st  [NDUT];
    logic       dn  [NDUT];
    logic       ln  [NDUT];

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned next_ok [NDUT];
    int          vectors = 0;
    int          miscompares = 0;
    logic        end_req = 1'b0;
    logic        end_done = 1'b0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx #(
            .BAUD_DIV  (CDIV[g]),
            .PARITY_EN (CPEN[g]),
            .PARITY_ODD(CPODD[g]),
            .STOP_BITS (CSTOP[g])
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .TX_EN    (en[g]),
            .TX_DATA  (dat[g]),
            .TX_STATUS(st[g]),
            .TX_DONE  (dn[g]),
            .UART_TX  (ln[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned frame_len(input int unsigned g);
        return (1 + 8 + CPEN[g] + CSTOP[g]) * CDIV[g];
    endfunction

    // Expected line level for every clock of the busy window, bit 0 first.
    function automatic logic [63:0] frame_bits(input int unsigned g, input logic [7:0] d);
        logic [63:0] v;
        logic [7:0]  t;
        logic        b;
        int unsigned pos;
        int unsigned nb;
        v   = '0;
        t   = d;
        pos = 0;
        nb  = 1 + 8 + CPEN[g] + CSTOP[g];
        for (int unsigned i = 0; i < nb; i++) begin
            if (i == 0) begin
                b = 1'b0;
            end else if (i <= 8) begin
                b = t[0];
                t = t >> 1;
            end else if (CPEN[g] != 0 && i == 9) begin
                b = 1'(($countones(d) + CPODD[g]) % 2);
            end else begin
                b = 1'b1;
            end
            for (int unsigned j = 0; j < CDIV[g]; j++) begin
                v[pos] = b;
                pos++;
            end
        end
        return v;
    endfunction

    // Monitor / checker
    initial begin : monitor
        logic        in_frame [NDUT];
        logic        have_exp [NDUT];
        logic        dseen    [NDUT];
        int unsigned cnt      [NDUT];
        int unsigned flen     [NDUT];
        logic [63:0] act      [NDUT];
        logic [63:0] expv     [NDUT];
        exp_t        e;
        for (int i = 0; i < int'(NDUT); i++) begin
            in_frame[i] = 1'b0;
            have_exp[i] = 1'b0;
            dseen[i]    = 1'b0;
            cnt[i]      = 0;
            flen[i]     = 0;
            act[i]      = '0;
            expv[i]     = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            for (int g = 0; g < int'(NDUT); g++) begin
                if (!rst_n) begin
                    vectors++;
                    if (ln[g] !== 1'b1 || st[g] !== 1'b0 || dn[g] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_state dut%0d: line/busy/done got %b%b%b, need 100",
                                 g, ln[g], st[g], dn[g]);
                    end
                    in_frame[g] = 1'b0;
                end else begin
                    if (!in_frame[g]) begin
                        if (st[g] === 1'b1) begin
                            in_frame[g] = 1'b1;
                            cnt[g]      = 0;
                            act[g]      = '0;
                            dseen[g]    = 1'b0;
                            vectors++;
                            if (sb.size() == 0) begin
                                miscompares++;
                                have_exp[g] = 1'b0;
                                $display("FAIL unexpected_frame dut%0d: frame started at cycle %0d, none expected",
                                         g, cyc);
                            end else begin
                                e = sb.pop_front();
                                have_exp[g] = 1'b1;
                                expv[g]     = frame_bits(g, e.data);
                                flen[g]     = frame_len(g);
                                if (e.id != g || cyc != e.acc + 1) begin
                                    miscompares++;
                                    $display("FAIL start_time dut%0d: started at cycle %0d, need dut%0d at cycle %0d",
                                             g, cyc, e.id, e.acc + 1);
                                end
                            end
                        end else begin
                            vectors++;
                            if (ln[g] !== 1'b1 || dn[g] !== 1'b0) begin
                                miscompares++;
                                $display("FAIL idle dut%0d: line/done got %b%b at cycle %0d, need 10",
                                         g, ln[g], dn[g], cyc);
                            end
                        end
                    end else if (st[g] !== 1'b1) begin
                        in_frame[g] = 1'b0;
                        if (have_exp[g]) begin
                            vectors++;
                            if (cnt[g] != flen[g]) begin
                                miscompares++;
                                $display("FAIL busy_len dut%0d: busy %0d clocks, need %0d",
                                         g, cnt[g], flen[g]);
                            end
                            vectors++;
                            if (act[g] !== expv[g]) begin
                                miscompares++;
                                $display("FAIL line_bits dut%0d: got %h, need %h", g, act[g], expv[g]);
                            end
                        end
                        vectors++;
                        if (dn[g] !== 1'b1 || ln[g] !== 1'b1 || dseen[g]) begin
                            miscompares++;
                            $display("FAIL done_pulse dut%0d: done/line got %b%b (early done %b), need 11 (0)",
                                     g, dn[g], ln[g], dseen[g]);
                        end
                    end
                    if (in_frame[g]) begin
                        if (cnt[g] < 64) act[g][cnt[g]] = ln[g];
                        cnt[g]++;
                        if (dn[g] !== 1'b0) dseen[g] = 1'b1;
                    end
                end
            end
            if (end_req && !end_done) begin
                end_done = 1'b1;
                vectors++;
                if (sb.size() != 0 || in_frame[0] || in_frame[1] || in_frame[2]) begin
                    miscompares++;
                    $display("FAIL drain: %0d frames still queued, busy flags %b%b%b, need 0 and 000",
                             sb.size(), in_frame[0], in_frame[1], in_frame[2]);
                end
            end
        end
    end

    // Drive TX_EN for 'hold' edges; the model accepts only when idle.
    task automatic send(input int unsigned g, input logic [7:0] d, input int unsigned hold);
        exp_t e;
        @(negedge clk);
        en[g]  = 1'b1;
        dat[g] = d;
        for (int unsigned h = 0; h < hold; h++) begin
            @(posedge clk);
            if (cyc >= next_ok[g]) begin
                e.id   = g;
                e.data = d;
                e.acc  = cyc;
                sb.push_back(e);
                next_ok[g] = cyc + frame_len(g) + 1;
            end
        end
        @(negedge clk);
        en[g]  = 1'b0;
        dat[g] = 8'($urandom);
    endtask

    task automatic gap(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        rst_n = 1'b0;
        for (int i = 0; i < int'(NDUT); i++) begin
            en[i]      = 1'b0;
            dat[i]     = 8'h00;
            next_ok[i] = 0;
        end
        gap(3);
        rst_n = 1'b1;

        // default framing, 0x55
        send(0, 8'h55, 1);
        gap(50);
        // strobe during a frame is ignored; data changes mid-frame
        send(0, 8'h12, 1);
        gap(9);
        send(0, 8'hFF, 1);
        gap(50);
        // back-to-back: second strobe lands in the done cycle
        send(0, 8'h81, 1);
        gap(frame_len(0) - 1);
        send(0, 8'h3C, 1);
        gap(50);
        // TX_EN held for several cycles gives one frame
        send(0, 8'h5A, 3);
        gap(50);
        // asynchronous reset in the middle of the data bits
        send(0, 8'hC6, 1);
        gap(14);
        #2 rst_n = 1'b0;
        gap(2);
        rst_n = 1'b1;
        for (int i = 0; i < int'(NDUT); i++) next_ok[i] = 0;
        send(0, 8'h42, 1);
        gap(50);

        // parity even with two stop bits
        send(1, 8'h07, 1);
        gap(60);
        send(1, 8'hA3, 1);
        gap(60);
        // odd parity
        send(2, 8'h00, 1);
        gap(50);

        // random bytes, gaps and strobe widths on every configuration
        for (int unsigned g = 0; g < NDUT; g++) begin
            for (int k = 0; k < 15; k++) begin
                gap($urandom_range(0, frame_len(g) + 6));
                send(g, 8'($urandom), $urandom_range(1, 2));
            end
            gap(70);
        end

        end_req = 1'b1;
        gap(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
